if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch stage between the PC register and the IF/ID register. Issues one
//  IM read per accepted PC, tracks in-order responses in a DEPTH-entry queue, presents
//  {instr, pc, pc8} to decode with valid/ready and tells the PC register when to hold.
//  Discards queued and in-flight fetches on a control-flow redirect (flush).
// PARAMETERS
//  DEPTH     2            queue entries = max outstanding IM requests (power of 2, >=2)
//  PC_RESET  32'h00003000 PC value loaded on reset (mirrors `PC_RESET in macro.v)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  pc         in   32  current PC from PC register
//  pc_stall   out  1   1 = PC register holds; 0 = PC register loads its next value
//  flush      in   1   redirect from branch/jump resolution; PC loads target this cycle
//  im_req     out  1   IM read request (combinational)
//  im_addr    out  32  IM address = pc
//  im_gnt     in   1   IM accepted request this cycle
//  im_rvalid  in   1   IM read data valid (in request order, >=1 cycle after grant)
//  im_rdata   in   32  instruction word
//  id_valid   out  1   head entry holds a fetched instruction
//  id_ready   in   1   decode accepts (= ~hazard stall)
//  id_instr   out  32  head instruction
//  id_pc      out  32  head PC
//  id_pc8     out  32  head PC + 8 (link address)
// BEHAVIOUR
//  - Entry state: FREE / PEND (PC known, data awaited) / RDY. Pointers alloc (tail),
//    fill (oldest PEND), head; all wrap mod DEPTH.
//  - im_req = ~reset & ~flush & slot[alloc]==FREE & (drop_cnt + n_pend) < DEPTH.
//  - fire = im_req & im_gnt: slot[alloc] <= {PEND, pc}; alloc++.
//  - pc_stall = ~(fire | flush); forced 1 in reset. PC advances only on accepted fetch.
//  - im_rvalid with drop_cnt==0 and no flush: slot[fill] <= {RDY, im_rdata}; fill++.
//    im_rvalid with drop_cnt>0: data discarded, drop_cnt--.
//  - id_valid = slot[head]==RDY; pop = id_valid & id_ready: slot[head]<=FREE; head++.
//    id_* driven from registered slot contents; min latency grant->id_valid = 2 cycles
//    (rvalid registered, no bypass to id_*).
//  - flush: all slots FREE, pointers to 0, id_valid 0 next cycle, pop ignored that
//    cycle; drop_cnt <= drop_cnt + n_pend - (im_rvalid ? 1 : 0). No request that cycle.
//  - Simultaneous fire, rvalid fill and pop in one cycle all allowed (distinct slots).
//  - Full (no FREE slot): im_req 0, pc_stall 1. Empty: id_valid 0, id_* hold last value.
//  - Invariant: outstanding IM reads (n_pend + drop_cnt) <= DEPTH; drop_cnt width
//    $clog2(DEPTH+1).
//  - reset: all slots FREE, pointers 0, drop_cnt 0, id_valid 0, id_instr/id_pc 0,
//    id_pc8 8; IM shares reset, so no stale responses arrive afterwards.
//  - rvalid with no PEND slot and drop_cnt==0 is illegal; simulation assertion fires.
// STRUCTURE
//  - macro.v: `PC_RESET, slot-state encodings `SLOT_FREE/`SLOT_PEND/`SLOT_RDY.
//  - One sub-module: if_fetch_slot (state + pc + instr register, alloc/fill/free/clear
//    ports), instantiated DEPTH times via generate; pointer/drop logic in top.
// TESTING
//  1 reset, im_gnt=1, rvalid 1 cycle after grant, id_ready=1 -> im_addr 0x3000,0x3004,
//    ...; id_pc 0x3000 first valid 2 cycles after grant, one instr/cycle, id_pc8 0x3008.
//  2 id_ready=0 for 4 cycles -> queue fills after DEPTH grants, im_req 0, pc_stall 1;
//    release -> in-order drain 0x3000,0x3004, fetching resumes at 0x3008.
//  3 im_gnt=0 for 3 cycles -> pc_stall 1, im_addr stays 0x3000, no allocation.
//  4 2 PEND slots, flush with pc target 0x3100 -> drop_cnt 2, next two rvalids ignored,
//    first id_pc after flush = 0x3100.
//  5 flush same cycle as rvalid, 1 PEND + drop_cnt 1 -> drop_cnt 1; pop same cycle ignored.
//  6 reset asserted with full queue and pending reads -> next cycle id_valid 0,
//    im_addr 0x3000 request, drop_cnt 0.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_pkg
//   Shared types and constants for the instruction-fetch queue.
//   slot_state_t  : life cycle of one queue entry (FREE -> PEND -> RDY -> FREE)
//   PC_RESET_DEFAULT : PC value the PC register loads on reset
//   LINK_OFFSET   : offset from an instruction's PC to its link address
// -----------------------------------------------------------------------------
package if_fetch_queue_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,   // entry unused
        SLOT_PEND = 2'd1,   // PC known, IM data still outstanding
        SLOT_RDY  = 2'd2    // instruction word captured, waiting for decode
    } slot_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] LINK_OFFSET      = 32'd8;

endpackage

// File: rtl/if_fetch_slot.sv
// -----------------------------------------------------------------------------
// if_fetch_slot
//   One entry of the fetch queue: state, fetch PC and instruction word.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     i_clear        drop the entry (redirect); pc/instr contents are kept
//     i_alloc        new fetch accepted into this entry, i_alloc_pc is its PC
//     i_fill         IM data for this entry arrived, i_fill_instr is the word
//     i_free         decode consumed this entry
//     o_state        current entry state
//     o_pc, o_instr  registered entry contents
//   The top only ever targets one of alloc/fill/free at a given entry in a
//   cycle, so their ordering below is not significant.
// -----------------------------------------------------------------------------
module if_fetch_slot
    import if_fetch_queue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_alloc,
    input  logic [31:0] i_alloc_pc,
    input  logic        i_fill,
    input  logic [31:0] i_fill_instr,
    input  logic        i_free,
    output slot_state_t o_state,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    slot_state_t r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SLOT_FREE;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_clear) begin
            r_state <= SLOT_FREE;
        end else if (i_alloc) begin
            r_state <= SLOT_PEND;
            r_pc    <= i_alloc_pc;
        end else if (i_fill) begin
            r_state <= SLOT_RDY;
            r_instr <= i_fill_instr;
        end else if (i_free) begin
            r_state <= SLOT_FREE;
        end
    end

    assign o_state = r_state;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage between the PC register and the IF/ID register.
//   Issues one IM read per accepted PC, keeps up to DEPTH fetches in flight or
//   waiting in order, and presents {instr, pc, pc+8} to decode with
//   valid/ready. A redirect (flush) empties the queue; reads already issued
//   are counted in r_drop_cnt and their responses are thrown away on arrival.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     pc                    current PC from the PC register
//     pc_stall              1 = PC register holds, 0 = it loads its next value
//     flush                 control-flow redirect, PC loads its target this cycle
//     im_req, im_addr       IM read request (combinational), address = pc
//     im_gnt                IM accepted the request this cycle
//     im_rvalid, im_rdata   in-order IM read data
//     id_valid, id_ready    handshake towards decode
//     id_instr, id_pc       head instruction and its PC
//     id_pc8                head PC + 8 (link address)
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_stall,
    input  logic        flush,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_alloc_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_head_ptr;
    logic [CW-1:0] r_drop_cnt;
    logic [31:0]   r_last_pc;
    logic [31:0]   r_last_instr;
    logic          r_first_fetch;

    slot_state_t   w_state      [DEPTH];
    logic [31:0]   w_slot_pc    [DEPTH];
    logic [31:0]   w_slot_instr [DEPTH];
    logic [CW-1:0] w_n_pend;
    logic          w_room;
    logic          w_fire;
    logic          w_fill;
    logic          w_pop;

    always_comb begin
        w_n_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_state[i] == SLOT_PEND) begin
                w_n_pend = w_n_pend + CW'(1);
            end
        end
    end

    // Reads in flight, live or already discarded, must never exceed DEPTH.
    assign w_room = ({1'b0, r_drop_cnt} + {1'b0, w_n_pend}) < (CW+1)'(DEPTH);

    assign im_req   = ~reset & ~flush & (w_state[r_alloc_ptr] == SLOT_FREE) & w_room;
    assign im_addr  = pc;
    assign w_fire   = im_req & im_gnt;
    assign pc_stall = reset | ~(w_fire | flush);

    // Responses owed to discarded fetches come first, before any live PEND.
    assign w_fill = im_rvalid & (r_drop_cnt == '0) & ~flush & ~reset;

    assign id_valid = (w_state[r_head_ptr] == SLOT_RDY);
    assign w_pop    = id_valid & id_ready & ~flush & ~reset;

    // With the queue empty decode keeps seeing the last presented entry.
    assign id_instr = id_valid ? w_slot_instr[r_head_ptr] : r_last_instr;
    assign id_pc    = id_valid ? w_slot_pc[r_head_ptr]    : r_last_pc;
    assign id_pc8   = id_pc + LINK_OFFSET;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if_fetch_slot u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_clear      (flush),
            .i_alloc      (w_fire && (r_alloc_ptr == PW'(g))),
            .i_alloc_pc   (pc),
            .i_fill       (w_fill && (r_fill_ptr == PW'(g))),
            .i_fill_instr (im_rdata),
            .i_free       (w_pop && (r_head_ptr == PW'(g))),
            .o_state      (w_state[g]),
            .o_pc         (w_slot_pc[g]),
            .o_instr      (w_slot_instr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_drop_cnt  <= '0;
        end else if (flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            // Every live PEND becomes a read to discard; a response arriving
            // right now retires one of them immediately.
            r_drop_cnt  <= r_drop_cnt + w_n_pend - CW'(im_rvalid);
        end else begin
            if (w_fire) r_alloc_ptr <= r_alloc_ptr + PW'(1);
            if (w_fill) r_fill_ptr  <= r_fill_ptr + PW'(1);
            if (w_pop)  r_head_ptr  <= r_head_ptr + PW'(1);
            if (im_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_pc    <= '0;
            r_last_instr <= '0;
        end else if (id_valid) begin
            r_last_pc    <= w_slot_pc[r_head_ptr];
            r_last_instr <= w_slot_instr[r_head_ptr];
        end
    end

    // Tracks the first fetch out of reset so the PC register's reset value
    // can be cross-checked against PC_RESET.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_fetch <= 1'b1;
        end else if (w_fire || flush) begin
            r_first_fetch <= 1'b0;
        end
    end

    a_first_pc : assert property (@(posedge clk) disable iff (reset)
        (w_fire && r_first_fetch) |-> (pc == PC_RESET))
        else $error("first fetch after reset not at PC_RESET");

    a_rvalid_owner : assert property (@(posedge clk) disable iff (reset)
        im_rvalid |-> ((r_drop_cnt != '0) || (w_n_pend != '0)))
        else $error("IM response with no outstanding read");

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_stall;
    logic        flush;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .pc_stall  (pc_stall),
        .flush     (flush),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_gnt    (im_gnt),
        .im_rvalid (im_rvalid),
        .im_rdata  (im_rdata),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_pc8    (id_pc8)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: fetches awaiting data, fetches ready for decode,
    // discarded reads still owed by the IM.
    logic [31:0] pend_q[$];
    logic [31:0] rdy_pc_q[$];
    logic [31:0] rdy_instr_q[$];
    int          m_drop = 0;
    logic [31:0] im_q[$];
    bit          rv_en = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] tgt = 32'h0;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        exp_req;
        logic        exp_fire;
        logic        exp_valid;
        logic        exp_pop;
        logic [31:0] next_pc;
        logic [31:0] a;
        int          np;

        @(negedge clk);
        im_rvalid = rv_en && !reset && (im_q.size() > 0);
        im_rdata  = im_rvalid ? im_word(im_q[0]) : 32'h0;
        #1;
        np        = pend_q.size();
        exp_req   = !reset && !flush && ((np + rdy_pc_q.size()) < DEPTH) && ((m_drop + np) < DEPTH);
        exp_fire  = exp_req && im_gnt;
        exp_valid = rdy_pc_q.size() > 0;
        exp_pop   = exp_valid && id_ready && !flush && !reset;

        if (chk_en) begin
            check("im_req",   32'(im_req),   32'(exp_req));
            check("pc_stall", 32'(pc_stall), 32'(reset || !(exp_fire || flush)));
            check("im_addr",  im_addr,       pc);
            check("id_valid", 32'(id_valid), 32'(exp_valid));
            check("drop_cnt", 32'(dut.r_drop_cnt), 32'(m_drop));
            if (exp_valid) begin
                check("id_pc",    id_pc,    rdy_pc_q[0]);
                check("id_instr", id_instr, rdy_instr_q[0]);
                check("id_pc8",   id_pc8,   rdy_pc_q[0] + 32'd8);
            end
        end

        // IM side follows the bus as driven by the DUT.
        if (reset) begin
            im_q.delete();
        end else begin
            if (im_rvalid) void'(im_q.pop_front());
            if (im_req && im_gnt) im_q.push_back(im_addr);
        end

        next_pc = pc;
        if (reset) begin
            pend_q.delete();
            rdy_pc_q.delete();
            rdy_instr_q.delete();
            m_drop  = 0;
            next_pc = 32'h0000_3000;
        end else if (flush) begin
            m_drop = m_drop + np - (im_rvalid ? 1 : 0);
            pend_q.delete();
            rdy_pc_q.delete();
            rdy_instr_q.delete();
            next_pc = tgt;
        end else begin
            if (exp_pop) begin
                void'(rdy_pc_q.pop_front());
                void'(rdy_instr_q.pop_front());
            end
            if (im_rvalid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else if (np > 0) begin
                    a = pend_q.pop_front();
                    rdy_pc_q.push_back(a);
                    rdy_instr_q.push_back(im_word(a));
                end
            end
            if (exp_fire) begin
                pend_q.push_back(pc);
                next_pc = pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        pc     = next_pc;
        chk_en = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        im_gnt    = 1'b0;
        id_ready  = 1'b0;
        im_rvalid = 1'b0;
        im_rdata  = 32'h0;
        pc        = 32'h0000_3000;

        // reset, then streaming fetch with 1-cycle IM latency
        repeat (2) cycle();
        reset = 1'b0; im_gnt = 1'b1; id_ready = 1'b1; rv_en = 1'b1;
        repeat (10) cycle();

        // decode stalls: queue fills, then drains in order
        id_ready = 1'b0;
        repeat (5) cycle();
        id_ready = 1'b1;
        repeat (6) cycle();

        // no grant right after reset: PC held at reset value
        reset = 1'b1; cycle();
        reset = 1'b0; im_gnt = 1'b0;
        repeat (3) cycle();
        im_gnt = 1'b1;
        repeat (4) cycle();

        // two reads outstanding, redirect to 0x3100
        rv_en = 1'b0;
        repeat (4) cycle();
        flush = 1'b1; tgt = 32'h0000_3100; cycle();
        flush = 1'b0; rv_en = 1'b1;
        repeat (8) cycle();

        // one live PEND plus one discarded read, flush meets a response
        im_gnt = 1'b0;
        repeat (4) cycle();
        im_gnt = 1'b1; rv_en = 1'b0; cycle();
        flush = 1'b1; tgt = 32'h0000_3200; cycle();
        flush = 1'b0; cycle();
        flush = 1'b1; tgt = 32'h0000_3300; rv_en = 1'b1; cycle();
        flush = 1'b0;
        repeat (6) cycle();

        // flush while decode would pop the head
        id_ready = 1'b0;
        repeat (4) cycle();
        id_ready = 1'b1; flush = 1'b1; tgt = 32'h0000_3400; cycle();
        flush = 1'b0;
        repeat (4) cycle();

        // reset with full queue and reads in flight
        id_ready = 1'b0; rv_en = 1'b0;
        repeat (3) cycle();
        reset = 1'b1; cycle();
        reset = 1'b0; id_ready = 1'b1; rv_en = 1'b1;
        repeat (6) cycle();

        // random mix of grants, latencies, stalls and redirects
        repeat (300) begin
            im_gnt   = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 3) != 0);
            rv_en    = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            tgt      = 32'h0000_4000 + (32'($urandom_range(0, 255)) << 2);
            cycle();
        end
        flush = 1'b0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
